// File: rtl/functional_counter_pkg.sv
// Shared op encodings and sizing helpers for the functional_counter_n family.
package functional_counter_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Default modulus ceiling: all ones at the given width.
  function automatic int unsigned default_max_val(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/fcnt_next_val.sv
// Combinational next-count datapath: clamps step/load, then wraps or saturates.
// FUNCTIONAL_COUNTER_N_SAT_EN selects saturation instead of modulo wrap.
module fcnt_next_val
  import functional_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = default_max_val(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next_q,
  output logic             boundary
);

  localparam int unsigned XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);
  localparam logic [XW-1:0]    MOD_X = XW'(MAX_VAL) + XW'(1);

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] d_eff;
  logic [XW-1:0]    sum_x;
  logic [XW-1:0]    q_x;
  logic [XW-1:0]    s_x;

  assign s_eff = (step > MAX_W) ? MAX_W : step;
  assign d_eff = (d > MAX_W) ? MAX_W : d;
  assign q_x   = {1'b0, q};
  assign s_x   = {1'b0, s_eff};
  assign sum_x = q_x + s_x;

  always_comb begin
    next_q   = q;
    boundary = 1'b0;
    case (op_e'(op))
      OP_UP: begin
        if (sum_x > MAX_X) begin
          boundary = 1'b1;
`ifdef FUNCTIONAL_COUNTER_N_SAT_EN
          next_q   = MAX_W;
`else
          next_q   = WIDTH'(sum_x - MOD_X);
`endif
        end else begin
          next_q = WIDTH'(sum_x);
        end
      end
      OP_DOWN: begin
        if (s_x > q_x) begin
          boundary = 1'b1;
`ifdef FUNCTIONAL_COUNTER_N_SAT_EN
          next_q   = '0;
`else
          next_q   = WIDTH'(q_x + MOD_X - s_x);
`endif
        end else begin
          next_q = WIDTH'(q_x - s_x);
        end
      end
      OP_LOAD: next_q = d_eff;
      default: next_q = q;
    endcase
  end

endmodule

// File: rtl/functional_counter_n.sv
// WIDTH-bit up/down/load counter with modulus, step, enable, tc pulse and sticky wrap flag.
// Define FUNCTIONAL_COUNTER_N_SAT_EN for saturating instead of wrapping arithmetic.
module functional_counter_n
  import functional_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = default_max_val(WIDTH)
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] step,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_flag
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] next_q;
  logic             boundary;

  fcnt_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .q        (q_q),
    .op       (op),
    .d        (d),
    .step     (step),
    .next_q   (next_q),
    .boundary (boundary)
  );

  // Enable gates everything; a boundary event beats a same-cycle flag clear.
  always_comb begin
    q_d    = q_q;
    tc_d   = 1'b0;
    wrap_d = wrap_q;
    if (en) begin
      q_d  = next_q;
      tc_d = boundary;
      if (boundary) begin
        wrap_d = 1'b1;
      end else if (flag_clr) begin
        wrap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign q         = q_q;
  assign tc        = tc_q;
  assign wrap_flag = wrap_q;

endmodule
